// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: PC handshake, instruction-memory port, decode control and IF/ID outputs.
// master = fetch stage, slave = surrounding pipeline / memory.
interface fetch_stage_if;
   logic [31:0] pc;
   logic        pcHold;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemAck;
   logic [31:0] imemData;
   logic        stall;
   logic        flush;
   logic [31:0] instrOut;
   logic [31:0] pcPlus4Out;
   logic        instrValid;
   logic        alignErr;
   logic        timeout;

   modport master (
      input  pc, imemAck, imemData, stall, flush,
      output pcHold, imemReq, imemAddr, instrOut, pcPlus4Out, instrValid, alignErr, timeout
   );

   modport slave (
      output pc, imemAck, imemData, stall, flush,
      input  pcHold, imemReq, imemAddr, instrOut, pcPlus4Out, instrValid, alignErr, timeout
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues imem reads, loads the IF/ID register, and parks one
// fetched word in a hold buffer when decode stalls. Sticky alignment and timeout flags.
module fetch_stage #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter int unsigned MAX_WAIT  = 8
) (
   input logic           clk,
   input logic           rst,
   fetch_stage_if.master fif
);
   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state_q;
   logic [XLEN-1:0]   instr_q;
   logic [XLEN-1:0]   pc4_q;
   logic              valid_q;
   logic              align_err_q;
   logic              timeout_q;
   logic [CNT_W-1:0]  wait_cnt_q;
   logic [XLEN-1:0]   hold_instr_q;
   logic [XLEN-1:0]   hold_pc4_q;

   logic              req_c;
   logic              hold_c;
   logic              ack_c;
   logic [CNT_W-1:0]  cnt_inc_c;
   logic [XLEN-1:0]   pc_plus4_c;

   // Request and PC-hold decode; flush releases the PC so it can take the redirect.
   always_comb begin
      req_c  = 1'b0;
      hold_c = 1'b1;
      if (!rst) begin
         case (state_q)
            FETCH: begin
               req_c  = (fif.pc[1:0] == 2'b00) && !align_err_q;
               hold_c = !(req_c && fif.imemAck && !fif.stall);
            end
            FULL:    hold_c = fif.stall;
            default: hold_c = 1'b1;
         endcase
         if (fif.flush) hold_c = 1'b0;
      end
   end

   assign ack_c      = req_c && fif.imemAck;
   assign cnt_inc_c  = (wait_cnt_q == CNT_MAX) ? CNT_MAX : wait_cnt_q + CNT_W'(1);
   assign pc_plus4_c = fif.pc + XLEN'(4);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         instr_q      <= NOP_INSTR;
         pc4_q        <= '0;
         valid_q      <= 1'b0;
         align_err_q  <= 1'b0;
         timeout_q    <= 1'b0;
         wait_cnt_q   <= '0;
         hold_instr_q <= '0;
         hold_pc4_q   <= '0;
      end else begin
         if (fif.flush) begin
            instr_q    <= NOP_INSTR;
            pc4_q      <= '0;
            valid_q    <= 1'b0;
            wait_cnt_q <= '0;
            state_q    <= FETCH;
         end else begin
            case (state_q)
               IDLE: begin
                  wait_cnt_q <= '0;
                  state_q    <= FETCH;
               end
               FETCH: begin
                  if (ack_c) begin
                     wait_cnt_q <= '0;
                     if (fif.stall) begin
                        hold_instr_q <= fif.imemData;
                        hold_pc4_q   <= pc_plus4_c;
                        state_q      <= FULL;
                     end else begin
                        instr_q <= fif.imemData;
                        pc4_q   <= pc_plus4_c;
                        valid_q <= 1'b1;
                     end
                  end else if (req_c) begin
                     wait_cnt_q <= cnt_inc_c;
                     if (cnt_inc_c >= WAIT_LIM) timeout_q <= 1'b1;
                  end
               end
               FULL: begin
                  if (!fif.stall) begin
                     instr_q    <= hold_instr_q;
                     pc4_q      <= hold_pc4_q;
                     valid_q    <= 1'b1;
                     wait_cnt_q <= '0;
                     state_q    <= FETCH;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
         // A misaligned PC presented while fetching latches the error until reset.
         if (state_q == FETCH && fif.pc[1:0] != 2'b00) align_err_q <= 1'b1;
      end
   end

   assign fif.pcHold     = hold_c;
   assign fif.imemReq    = req_c;
   assign fif.imemAddr   = fif.pc;
   assign fif.instrOut   = instr_q;
   assign fif.pcPlus4Out = pc4_q;
   assign fif.instrValid = valid_q;
   assign fif.alignErr   = align_err_q;
   assign fif.timeout    = timeout_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus a bounded timeout-latency sequence.
module tb_fetch_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   fetch_stage_if fif ();

   fetch_stage #(.NOP_INSTR(NOP), .MAX_WAIT(8)) dut (
      .clk (clk),
      .rst (rst),
      .fif (fif)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [31:0] pc;
      logic        ack;
      logic [31:0] data;
      logic        stall;
      logic        flush;
      logic        hold;
      logic        req;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic        aerr;
      logic        tmo;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic [31:0] p, input logic a, input logic [31:0] d,
                      input logic s, input logic f, input logic h, input logic q,
                      input logic [31:0] i, input logic [31:0] p4, input logic v,
                      input logic ae, input logic t);
      vec_t x;
      x.rst = r; x.pc = p; x.ack = a; x.data = d; x.stall = s; x.flush = f;
      x.hold = h; x.req = q; x.instr = i; x.pc4 = p4; x.valid = v; x.aerr = ae; x.tmo = t;
      vecs.push_back(x);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [31:0] p, input logic a, input logic [31:0] d,
                        input logic s, input logic f);
      rst = r; fif.pc = p; fif.imemAck = a; fif.imemData = d; fif.stall = s; fif.flush = f;
   endtask

   initial begin
      int cycles;

      //   rst pc            ack data           stl fl | hold req instr          pc4           v  ae t
      add(1, 32'h0,        0, 32'h0,        0, 0,  1, 0, NOP,           32'h0,        0, 0, 0);
      add(1, 32'h0,        0, 32'h0,        0, 0,  1, 0, NOP,           32'h0,        0, 0, 0);
      add(0, 32'h0,        1, 32'h20080005, 0, 0,  1, 0, NOP,           32'h0,        0, 0, 0);
      add(0, 32'h0,        1, 32'h20080005, 0, 0,  0, 1, 32'h20080005,  32'h4,        1, 0, 0);
      add(0, 32'h4,        1, 32'h11111111, 0, 0,  0, 1, 32'h11111111,  32'h8,        1, 0, 0);
      add(0, 32'h8,        0, 32'h0,        0, 0,  1, 1, 32'h11111111,  32'h8,        1, 0, 0);
      add(0, 32'h8,        0, 32'h0,        1, 0,  1, 1, 32'h11111111,  32'h8,        1, 0, 0);
      add(0, 32'h8,        1, 32'h22222222, 0, 0,  0, 1, 32'h22222222,  32'hC,        1, 0, 0);
      // stalled ack parks in the hold buffer for three cycles
      add(0, 32'h10,       1, 32'hAABBCCDD, 1, 0,  1, 1, 32'h22222222,  32'hC,        1, 0, 0);
      add(0, 32'h10,       1, 32'hDEADBEEF, 1, 0,  1, 0, 32'h22222222,  32'hC,        1, 0, 0);
      add(0, 32'h10,       0, 32'h0,        1, 0,  1, 0, 32'h22222222,  32'hC,        1, 0, 0);
      add(0, 32'h10,       1, 32'hDEADBEEF, 0, 0,  0, 0, 32'hAABBCCDD,  32'h14,       1, 0, 0);
      add(0, 32'hFFFFFFFC, 1, 32'h33333333, 0, 0,  0, 1, 32'h33333333,  32'h0,        1, 0, 0);
      // flush discards a same-cycle ack, and wins over stall in FULL
      add(0, 32'h40,       1, 32'h44444444, 0, 1,  0, 1, NOP,           32'h0,        0, 0, 0);
      add(0, 32'h40,       1, 32'h55555555, 1, 0,  1, 1, NOP,           32'h0,        0, 0, 0);
      add(0, 32'h40,       0, 32'h0,        1, 1,  0, 0, NOP,           32'h0,        0, 0, 0);
      add(0, 32'h44,       1, 32'h66666666, 0, 0,  0, 1, 32'h66666666,  32'h48,       1, 0, 0);
      for (int k = 0; k < 9; k++)
         add(0, 32'h48,    0, 32'h0,        0, 0,  1, 1, 32'h66666666,  32'h48,       1, 0, logic'(k >= 7));
      add(0, 32'h48,       1, 32'h77777777, 0, 0,  0, 1, 32'h77777777,  32'h4C,       1, 0, 1);
      // misaligned pc: no request, sticky error blocks later fetches
      add(0, 32'h6,        1, 32'h88888888, 0, 0,  1, 0, 32'h77777777,  32'h4C,       1, 1, 1);
      add(0, 32'h8,        1, 32'h99999999, 0, 0,  1, 0, 32'h77777777,  32'h4C,       1, 1, 1);
      add(0, 32'h8,        0, 32'h0,        0, 1,  0, 0, NOP,           32'h0,        0, 1, 1);
      add(1, 32'h8,        0, 32'h0,        0, 0,  1, 0, NOP,           32'h0,        0, 0, 0);
      add(0, 32'h0,        0, 32'h0,        0, 0,  1, 0, NOP,           32'h0,        0, 0, 0);
      add(0, 32'h0,        0, 32'h0,        0, 0,  1, 1, NOP,           32'h0,        0, 0, 0);
      // reset mid-request drops the ack
      add(1, 32'h0,        1, 32'hABCDEF01, 0, 0,  1, 0, NOP,           32'h0,        0, 0, 0);
      add(0, 32'h0,        1, 32'hABCDEF01, 0, 0,  1, 0, NOP,           32'h0,        0, 0, 0);
      add(0, 32'h20,       1, 32'h12345678, 0, 0,  0, 1, 32'h12345678,  32'h24,       1, 0, 0);

      foreach (vecs[n]) begin
         drive(vecs[n].rst, vecs[n].pc, vecs[n].ack, vecs[n].data, vecs[n].stall, vecs[n].flush);
         #1;
         check($sformatf("v%0d pcHold", n), 32'(fif.pcHold), 32'(vecs[n].hold));
         check($sformatf("v%0d imemReq", n), 32'(fif.imemReq), 32'(vecs[n].req));
         if (vecs[n].req) check($sformatf("v%0d imemAddr", n), fif.imemAddr, vecs[n].pc);
         @(posedge clk);
         #1;
         check($sformatf("v%0d instrOut", n), fif.instrOut, vecs[n].instr);
         check($sformatf("v%0d pcPlus4Out", n), fif.pcPlus4Out, vecs[n].pc4);
         check($sformatf("v%0d instrValid", n), 32'(fif.instrValid), 32'(vecs[n].valid));
         check($sformatf("v%0d alignErr", n), 32'(fif.alignErr), 32'(vecs[n].aerr));
         check($sformatf("v%0d timeout", n), 32'(fif.timeout), 32'(vecs[n].tmo));
      end

      // Timeout latency: count waiting edges until the flag rises, bounded.
      drive(1, 32'h0, 0, 32'h0, 0, 0);
      @(posedge clk); #1;
      drive(0, 32'h0, 0, 32'h0, 0, 0);
      @(posedge clk); #1;
      check("seq timeout_clear", 32'(fif.timeout), 32'h0);
      cycles = 0;
      do begin
         @(posedge clk); #1;
         cycles++;
      end while (!fif.timeout && cycles < 20);
      check("seq timeout_latency", 32'(cycles), 32'd8);
      check("seq req_after_timeout", 32'(fif.imemReq), 32'h1);
      drive(0, 32'h0, 1, 32'hCAFEF00D, 0, 0);
      @(posedge clk); #1;
      check("seq late_ack_instr", fif.instrOut, 32'hCAFEF00D);
      check("seq late_ack_valid", 32'(fif.instrValid), 32'h1);
      check("seq timeout_sticky", 32'(fif.timeout), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
